// File: rtl/db15_serial_reader.sv
// Scans two DB15 pads through a 74HC165-style PISO chain and presents
// two active-high joystick words, refreshed once per scan period.
module db15_serial_reader #(
   parameter int HALF        = 25,
   parameter int NBITS       = 24,
   parameter int SCAN_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        joy_clk,
   output logic        joy_load,
   input  logic        joy_data,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        present,
   output logic        scan_done
);

   localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int KW = $clog2(NBITS);
   localparam int NH = NBITS / 2;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_LOW, S_HIGH, S_UPDATE
   } state_t;

   state_t           state;
   logic [PW-1:0]    per_cnt;
   logic [HW-1:0]    hcnt;
   logic [KW-1:0]    k;
   logic [NBITS-1:0] acc;
   logic             req_q;
   logic             period_hit;
   logic             start;
   logic             last;
   logic [15:0]      j1_nxt;
   logic [15:0]      j2_nxt;
   logic             pres_nxt;

   assign period_hit = (per_cnt == PW'(SCAN_CYCLES - 1));
   assign start      = req_q | period_hit;
   assign last       = (hcnt == '0);

   // A chain that reads all zeros means the pull-down won: no pad attached.
   always_comb begin
      j1_nxt   = '0;
      j2_nxt   = '0;
      pres_nxt = (acc != '0);
      for (int i = 0; i < NH; i++) begin
         j1_nxt[i] = ~acc[i];
         j2_nxt[i] = ~acc[i+NH];
      end
      if (!pres_nxt) begin
         j1_nxt = '0;
         j2_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         per_cnt   <= '0;
         hcnt      <= '0;
         k         <= '0;
         acc       <= '0;
         req_q     <= 1'b0;
         joy_clk   <= 1'b0;
         joy_load  <= 1'b1;
         joystick1 <= '0;
         joystick2 <= '0;
         present   <= 1'b0;
         scan_done <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         per_cnt   <= period_hit ? '0 : per_cnt + 1'b1;
         hcnt      <= hcnt - 1'b1;
         if (period_hit)
            req_q <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  // A fresh hit coinciding with a consumed pending request stays queued.
                  req_q    <= req_q & period_hit;
                  state    <= S_LOAD;
                  joy_load <= 1'b0;
                  hcnt     <= HW'(HALF - 1);
               end
            end
            S_LOAD: begin
               if (last) begin
                  state    <= S_SETTLE;
                  joy_load <= 1'b1;
                  hcnt     <= HW'(HALF - 1);
               end
            end
            S_SETTLE: begin
               if (last) begin
                  state <= S_LOW;
                  k     <= '0;
                  hcnt  <= HW'(HALF - 1);
               end
            end
            S_LOW: begin
               if (last) begin
                  acc[k]  <= joy_data;
                  state   <= S_HIGH;
                  joy_clk <= 1'b1;
                  hcnt    <= HW'(HALF - 1);
               end
            end
            S_HIGH: begin
               if (last) begin
                  joy_clk <= 1'b0;
                  hcnt    <= HW'(HALF - 1);
                  if (k == KW'(NBITS - 1)) begin
                     state <= S_UPDATE;
                  end else begin
                     k     <= k + 1'b1;
                     state <= S_LOW;
                  end
               end
            end
            S_UPDATE: begin
               joystick1 <= j1_nxt;
               joystick2 <= j2_nxt;
               present   <= pres_nxt;
               scan_done <= 1'b1;
               // An overrun scan chains straight into the next one.
               if (start) begin
                  req_q    <= req_q & period_hit;
                  state    <= S_LOAD;
                  joy_load <= 1'b0;
                  hcnt     <= HW'(HALF - 1);
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/db15_serial_reader.md
Name: db15_serial_reader

Overview:
- Upstream stage of the UserIO joystick path: scans two DB15 pads through a daisy-chained parallel-in/serial-out shift-register chain (74HC165-style) on the user port.
- Drives the active-low load strobe and the shift clock, and samples the serial data line.
- Presents two active-high 16-bit joystick words to the top-level joystick mux.
- Words use the layout FEDCBAUDLR in bits [9:0]; bits [11:10] carry Select and Start.

Parameters:
HALF, 25, system-clock cycles per half period of joy_clk, and the joy_load pulse width (1..255).
NBITS, 24, bits per scan; the first NBITS/2 bits go to player 1, the rest to player 2 (even, 2..32).
SCAN_CYCLES, 50000, cycles between scan starts (must be >= 1).

Ports:
clk  in  1  system clock; runs at 40-50 MHz.
reset  in  1  synchronous, active-high reset.
joy_clk  out  1  shift clock to the chain; idles low; the chain shifts on the rising edge.
joy_load  out  1  active-low parallel-load strobe; idles high.
joy_data  in  1  serial data from the chain; active-low (0 = pressed).
joystick1  out  16  player 1 buttons, active-high; [15:NBITS/2] are always 0.
joystick2  out  16  player 2 buttons, active-high; [15:NBITS/2] are always 0.
present  out  1  high when the last scan saw a connected pad.
scan_done  out  1  one-cycle strobe when joystick1, joystick2 and present update.

Behaviour:
- Reset values: joy_clk=0, joy_load=1, joystick1=0, joystick2=0, present=0, scan_done=0.
  - On reset the FSM goes to IDLE, the period counter is set to 0, and the shift accumulator is cleared.
  - Reset mid-scan aborts the scan with no output update.
- Period counter: free-running, 0..SCAN_CYCLES-1, wraps to 0. The cycle where it equals SCAN_CYCLES-1 raises a start request.
  - The request is latched until IDLE consumes it.
  - If a scan overruns the period, the next scan starts on the cycle after UPDATE. Only one request is pending at a time; extra requests are dropped.
- FSM states:
  - IDLE: joy_clk=0, joy_load=1. Go to LOAD when a request is pending, and clear the request.
  - LOAD: joy_load=0 for HALF cycles, then go to SETTLE.
  - SETTLE: joy_load=1 for HALF cycles (QH shows bit 0), then go to LOW with bit index k=0.
  - LOW: joy_clk=0 for HALF cycles. On the last cycle, sample joy_data into acc[k], then go to HIGH.
  - HIGH: joy_clk=1 for HALF cycles. At the end, if k==NBITS-1 go to UPDATE; otherwise k<=k+1 and go to LOW.
  - UPDATE: one cycle, then IDLE. Registered outputs change on the following edge, together with scan_done=1 for exactly one cycle.
- Scan length from LOAD entry to UPDATE: 2*HALF + NBITS*2*HALF cycles. The final HIGH phase is completed, so joy_clk always returns low before IDLE.
- Data mapping: raw=~acc. joystick1[k]=raw[k] for k<NBITS/2; joystick2[k-NBITS/2]=raw[k] otherwise.
- Disconnect detection:
  - If acc is all zeros (line pulled low, every button "pressed") or all ones in the first NBITS/2 bits are held... simplified rule: present=0 exactly when acc is all zeros. In that case joystick1 and joystick2 are forced to 0.
  - Otherwise present=1 and the mapped values are output.
- Outputs hold their value between scans; there is no partial update.
- Counters use just enough bits for their range. The HALF counter reloads at each phase entry.

Test Plan:
- Use HALF=2, NBITS=24, SCAN_CYCLES=200 unless stated otherwise.
- Reset: hold reset 5 cycles → joy_clk=0, joy_load=1, all outputs 0. The first LOAD starts at cycle 200 after release. joy_load is low for exactly 2 cycles.
- Single scan: the chain model returns acc=24'hFFFFFE (P1 bit0 pressed) → scan_done pulses once. Then joystick1=16'h0001, joystick2=0, present=1. Exactly 24 joy_clk rising edges; scan length 100 cycles.
- Player split: only bit 12 low and bit 23 low → joystick1=0, joystick2=16'h0801.
- Disconnect: joy_data tied 0 → present=0, joystick1=joystick2=0, scan_done still pulses.
- Overrun: set SCAN_CYCLES=50 (scan 100 cycles) → the next LOAD begins the cycle after UPDATE. scan_done period is 101 cycles, with no skipped or doubled scans.
- Reset mid-scan: assert reset during bit 10 → outputs keep 0 (from prior reset) or revert to 0, joy_clk=0 next cycle, no scan_done. A normal scan follows at the next period.
